// File: rtl/mtp_pkg.sv
// Shared definitions for the MTP read sequencer.
//   - mtp_state_e : read FSM state encoding
//   - *_DEF       : default widths and timing
//   - SRC_INIT / SRC_CMD : encoding of rd_src
//   - cnt_load()  : 4-bit reload value for a phase lasting N cycles
package mtp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SENSE = 3'd2,
        LATCH = 3'd3,
        DONE  = 3'd4
    } mtp_state_e;

    localparam int ADDR_W_DEF    = 5;
    localparam int DATA_W_DEF    = 16;
    localparam int SENSE_CYC_DEF = 4;
    localparam int DONE_CYC_DEF  = 2;
    localparam int CNT_W         = 4;

    localparam logic SRC_INIT = 1'b0;
    localparam logic SRC_CMD  = 1'b1;

    // A phase of N cycles counts N-1 down to 0 and leaves on the edge that sees 0.
    function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/mtp_req_latch.sv
// Rising-edge detector with a one-deep pending flag for one read requester.
// Ports:
//   DOUB_BLF : clock (rising edge)
//   rst      : synchronous active-high reset
//   pulse    : request line; each sampled rising edge is one request
//   grant    : sequencer accepted the pending request on this edge
//   pending  : a request is waiting to be served
// The history register resets to 1 so a line already high during reset has to
// fall and rise again before it counts.  A new edge arriving on the grant edge
// is kept, so back-to-back requests are not lost; an edge arriving while the
// flag is already set is dropped.
module mtp_req_latch (
    input  logic DOUB_BLF,
    input  logic rst,
    input  logic pulse,
    input  logic grant,
    output logic pending
);

    logic pulse_d_r;
    logic pending_r;
    logic rise_s;

    // Rising edge of the request line relative to the previous sample.
    always_comb begin
        rise_s = 1'b0;
        if (pulse && !pulse_d_r) begin
            rise_s = 1'b1;
        end else begin
            rise_s = 1'b0;
        end
    end

    // Edge history and pending flag.
    always_ff @(posedge DOUB_BLF) begin
        if (rst) begin
            pulse_d_r <= 1'b1;
            pending_r <= 1'b0;
        end else begin
            pulse_d_r <= pulse;
            if (rise_s) begin
                pending_r <= 1'b1;
            end else if (grant) begin
                pending_r <= 1'b0;
            end
        end
    end

    assign pending = pending_r;

endmodule

// File: rtl/mtp_rd_ctrl.sv
// MTP read sequencer feeding the system init unit.
// Serves read requests from the init unit and the command decoder (init has
// priority) as timed MTP macro cycles: chip-enable, sense, latch, done strobe.
// Ports:
//   DOUB_BLF      : clock (rising edge)
//   rst           : synchronous active-high reset, aborts any read in flight
//   init_rd_pulse / init_pointer : init-unit request edge and word address
//   cmd_rd_pulse  / cmd_pointer  : command-decoder request edge and word address
//   mtp_dout      : raw word from the macro
//   mtp_addr, mtp_ce, mtp_oe     : macro address / chip enable / sense enable
//   mtp_data      : word latched by the last read (held until the next latch)
//   rd_done       : completion strobe, DONE_CYC cycles wide
//   rd_src        : owner of the current/last read (SRC_INIT / SRC_CMD)
//   busy          : sequencer not idle
// Optional feature, macro MTP_PARITY_EN: adds input mtp_par (odd parity over
// mtp_dout) and output rd_err.  A bad word is latched as zero and rd_err is
// raised for the same cycles as that read's rd_done.
module mtp_rd_ctrl
    import mtp_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SENSE_CYC = SENSE_CYC_DEF,
    parameter int DONE_CYC  = DONE_CYC_DEF
) (
    input  logic              DOUB_BLF,
    input  logic              rst,
    input  logic              init_rd_pulse,
    input  logic [ADDR_W-1:0] init_pointer,
    input  logic              cmd_rd_pulse,
    input  logic [ADDR_W-1:0] cmd_pointer,
    input  logic [DATA_W-1:0] mtp_dout,
`ifdef MTP_PARITY_EN
    input  logic              mtp_par,
    output logic              rd_err,
`endif
    output logic [ADDR_W-1:0] mtp_addr,
    output logic              mtp_ce,
    output logic              mtp_oe,
    output logic [DATA_W-1:0] mtp_data,
    output logic              rd_done,
    output logic              rd_src,
    output logic              busy
);

    mtp_state_e        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic              ce_r;
    logic              oe_r;
    logic              done_r;
    logic              src_r;
    logic              busy_r;

    logic              pend_init_s;
    logic              pend_cmd_s;
    logic              grant_init_s;
    logic              grant_cmd_s;
    logic              grant_any_s;
    logic              sense_end_s;
    logic [DATA_W-1:0] latch_word_s;

    mtp_req_latch u_init_req (
        .DOUB_BLF (DOUB_BLF),
        .rst      (rst),
        .pulse    (init_rd_pulse),
        .grant    (grant_init_s),
        .pending  (pend_init_s)
    );

    mtp_req_latch u_cmd_req (
        .DOUB_BLF (DOUB_BLF),
        .rst      (rst),
        .pulse    (cmd_rd_pulse),
        .grant    (grant_cmd_s),
        .pending  (pend_cmd_s)
    );

    // Grant only from IDLE; the init unit wins a tie.
    always_comb begin
        grant_init_s = 1'b0;
        grant_cmd_s  = 1'b0;
        if (state_r == IDLE) begin
            if (pend_init_s) begin
                grant_init_s = 1'b1;
            end else if (pend_cmd_s) begin
                grant_cmd_s = 1'b1;
            end else begin
                grant_init_s = 1'b0;
                grant_cmd_s  = 1'b0;
            end
        end else begin
            grant_init_s = 1'b0;
            grant_cmd_s  = 1'b0;
        end
    end

    assign grant_any_s = grant_init_s | grant_cmd_s;

    // Last sense cycle: the macro output is sampled on this edge.
    always_comb begin
        sense_end_s = 1'b0;
        if ((state_r == SENSE) && (cnt_r == {CNT_W{1'b0}})) begin
            sense_end_s = 1'b1;
        end else begin
            sense_end_s = 1'b0;
        end
    end

`ifdef MTP_PARITY_EN
    logic par_err_r;
    logic rd_err_r;

    // Odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic par_ok(input logic [DATA_W-1:0] d, input logic p);
        return ((^d) ^ p) == 1'b1;
    endfunction

    // A word failing parity is replaced by zero rather than passed on.
    always_comb begin
        latch_word_s = {DATA_W{1'b0}};
        if (par_ok(mtp_dout, mtp_par)) begin
            latch_word_s = mtp_dout;
        end else begin
            latch_word_s = {DATA_W{1'b0}};
        end
    end

    // Parity error flag: captured at latch time, shown only while rd_done is up.
    always_ff @(posedge DOUB_BLF) begin
        if (rst) begin
            par_err_r <= 1'b0;
            rd_err_r  <= 1'b0;
        end else if (grant_any_s) begin
            par_err_r <= 1'b0;
            rd_err_r  <= 1'b0;
        end else if (sense_end_s) begin
            par_err_r <= !par_ok(mtp_dout, mtp_par);
        end else if (state_r == LATCH) begin
            rd_err_r <= par_err_r;
        end else if ((state_r == DONE) && (cnt_r == {CNT_W{1'b0}})) begin
            rd_err_r <= 1'b0;
        end
    end

    assign rd_err = rd_err_r;
`else
    assign latch_word_s = mtp_dout;
`endif

    // Read sequencer FSM; every output is a register set on state entry.
    always_ff @(posedge DOUB_BLF) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            addr_r  <= {ADDR_W{1'b0}};
            data_r  <= {DATA_W{1'b0}};
            ce_r    <= 1'b0;
            oe_r    <= 1'b0;
            done_r  <= 1'b0;
            src_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_any_s) begin
                        state_r <= SETUP;
                        addr_r  <= grant_init_s ? init_pointer : cmd_pointer;
                        src_r   <= grant_init_s ? SRC_INIT : SRC_CMD;
                        ce_r    <= 1'b1;
                        busy_r  <= 1'b1;
                    end
                end
                SETUP: begin
                    state_r <= SENSE;
                    oe_r    <= 1'b1;
                    cnt_r   <= cnt_load(SENSE_CYC);
                end
                SENSE: begin
                    if (sense_end_s) begin
                        // Data is captured here, one cycle ahead of rd_done.
                        state_r <= LATCH;
                        oe_r    <= 1'b0;
                        data_r  <= latch_word_s;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                LATCH: begin
                    state_r <= DONE;
                    ce_r    <= 1'b0;
                    done_r  <= 1'b1;
                    cnt_r   <= cnt_load(DONE_CYC);
                end
                DONE: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= IDLE;
                        done_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ce_r    <= 1'b0;
                    oe_r    <= 1'b0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mtp_addr = addr_r;
    assign mtp_ce   = ce_r;
    assign mtp_oe   = oe_r;
    assign mtp_data = data_r;
    assign rd_done  = done_r;
    assign rd_src   = src_r;
    assign busy     = busy_r;

endmodule
